// File: rtl/mem_if_pkg.sv
// Shared types for the LSQ<->memory request interface: widths, rw codes, responder FSM states.
package mem_if_pkg;
    localparam int ID_W   = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
        logic [ID_W-1:0]   id;
    } req_t;
endpackage

// File: rtl/mem_req_fifo.sv
// In-order request buffer with show-ahead head; push on full and pop on empty are ignored.
// Count reflects pushes and pops from the previous edge, so full never anticipates a same-edge pop.
module mem_req_fifo
    import mem_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  req_t                   i_dat,
    input  logic                   i_pop,
    output req_t                   o_dat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);

    req_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: FIFO-ordered requests, one completion LATENCY edges after service start.
// stall_out is high while the request buffer is full; requests seen then are dropped.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rw_in,
    input  logic [ID_W-1:0]   id_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ID_W-1:0]   id_out,
    output logic              ready_out,
    output logic              stall_out
);
    localparam int IW    = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int CW    = $clog2(DEPTH) + 1;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    req_t              w_req;
    req_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_accept;
    logic              w_retire;
    logic [IW-1:0]     w_idx;
    logic              w_unused_addr_bits;

    assign w_req     = '{addr: addr_in, data: data_in, rw: rw_in, id: id_in};
    assign w_accept  = valid_in && !w_full;
    assign w_retire  = (r_state == BUSY) && (r_cnt == CNT_W'(1));
    assign w_idx     = w_head.addr[IW+1:2];
    assign stall_out = w_full;
    assign w_unused_addr_bits = ^{w_head.addr[ADDR_W-1:IW+2], w_head.addr[1:0]};

    mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_accept),
        .i_dat   (w_req),
        .i_pop   (w_retire),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
        end else if (w_retire && (w_head.rw == RW_WRITE)) begin
            r_mem[w_idx] <= w_head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            data_out  <= '0;
            id_out    <= '0;
            ready_out <= 1'b0;
        end else begin
            ready_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_empty) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_W'(LATENCY);
                    end
                end
                BUSY: begin
                    if (w_retire) begin
                        ready_out <= 1'b1;
                        id_out    <= w_head.id;
                        data_out  <= (w_head.rw == RW_WRITE) ? w_head.data : r_mem[w_idx];
                        // Next entry (possibly one landing this very edge) starts service now.
                        if ((w_count > CW'(1)) || w_accept) r_cnt <= CNT_W'(LATENCY);
                        else                                r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: timestamp-based reference model plus directed scenarios.
module tb_data_mem_responder;
    import mem_if_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int MW    = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] data_in = '0;
    logic        rw_in = 1'b0;
    logic [3:0]  id_in = '0;
    logic        valid_in = 1'b0;
    logic [31:0] data_out;
    logic [3:0]  id_out;
    logic        ready_out;
    logic        stall_out;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .MEM_WORDS(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .rw_in     (rw_in),
        .id_in     (id_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .id_out    (id_out),
        .ready_out (ready_out),
        .stall_out (stall_out)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: each request completes at max(accept edge, previous completion) + LAT.
    typedef struct {
        int          ct;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  id;
    } mreq_t;

    mreq_t       mq[$];
    mreq_t       m_new;
    logic [31:0] mmem [MW];
    int          cyc = 0;
    int          last_ct = 0;
    int          widx;
    bit          m_acc;
    logic        m_ready = 1'b0;
    logic [3:0]  m_id = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            last_ct = 0;
            m_ready = 1'b0;
            m_id    = '0;
            m_data  = '0;
            foreach (mmem[i]) mmem[i] = '0;
        end else begin
            cyc++;
            m_acc   = valid_in && (mq.size() < DEPTH);
            m_ready = 1'b0;
            if (mq.size() > 0 && mq[0].ct == cyc) begin
                widx = int'((mq[0].addr / 4) % MW);
                if (mq[0].rw) begin
                    mmem[widx] = mq[0].data;
                    m_data = mq[0].data;
                end else begin
                    m_data = mmem[widx];
                end
                m_id    = mq[0].id;
                m_ready = 1'b1;
                void'(mq.pop_front());
            end
            if (m_acc) begin
                m_new.ct   = ((cyc > last_ct) ? cyc : last_ct) + LAT;
                m_new.rw   = rw_in;
                m_new.addr = addr_in;
                m_new.data = data_in;
                m_new.id   = id_in;
                last_ct    = m_new.ct;
                mq.push_back(m_new);
            end
        end
    end

    logic [3:0]  log_id[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        chk("ready_out", {31'b0, ready_out}, {31'b0, m_ready});
        chk("id_out", {28'b0, id_out}, {28'b0, m_id});
        chk("data_out", data_out, m_data);
        chk("stall_out", {31'b0, stall_out}, {31'b0, (mq.size() == DEPTH)});
        if (ready_out) begin
            log_id.push_back(id_out);
            log_data.push_back(data_out);
        end
    end

    task automatic send(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] id);
        @(negedge clk);
        valid_in = 1'b1;
        rw_in    = rw;
        addr_in  = a;
        data_in  = d;
        id_in    = id;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic clear_log();
        log_id.delete();
        log_data.delete();
    endtask

    initial begin
        // Reset from power-up: outputs must clear as soon as rst rises.
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", {31'b0, ready_out}, 32'd0);
        chk("rst_id", {28'b0, id_out}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_stall", {31'b0, stall_out}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        clear_log();
        send(RW_READ, 32'h0, 32'hFFFF_FFFF, 4'd1);
        idle(4);
        chk("t1_count", log_id.size(), 32'd1);
        if (log_id.size() > 0) chk("t1_data", log_data[0], 32'h0);

        // Write then read same word, one cycle apart.
        clear_log();
        send(RW_WRITE, 32'h8, 32'hDEAD_BEEF, 4'd3);
        send(RW_READ, 32'h8, 32'h0, 4'd4);
        idle(1);
        @(negedge clk);
        chk("t2_ready_e2", {31'b0, ready_out}, 32'd1);
        chk("t2_id_e2", {28'b0, id_out}, 32'd3);
        chk("t2_data_e2", data_out, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_ready_e3", {31'b0, ready_out}, 32'd0);
        @(negedge clk);
        chk("t2_ready_e4", {31'b0, ready_out}, 32'd1);
        chk("t2_id_e4", {28'b0, id_out}, 32'd4);
        chk("t2_data_e4", data_out, 32'hDEAD_BEEF);
        idle(2);

        // Address wrap and ignored low bits: 0x1004 and 0x0006 both hit word 1.
        clear_log();
        send(RW_WRITE, 32'h1004, 32'h5A5A_5A5A, 4'd5);
        send(RW_READ, 32'h0006, 32'h0, 4'd6);
        idle(6);
        chk("t4_count", log_id.size(), 32'd2);
        if (log_id.size() > 1) begin
            chk("t4_id", {28'b0, log_id[1]}, 32'd6);
            chk("t4_data", log_data[1], 32'h5A5A_5A5A);
        end

        // Fill the buffer: six back-to-back reads fill it; the 7th is refused while
        // the head retires, then accepted on the following cycle.
        clear_log();
        for (int i = 1; i <= 6; i++) send(RW_READ, 32'(4 * i), 32'h0, 4'(i));
        send(RW_READ, 32'h1C, 32'h0, 4'd7);
        chk("t5_stall_full", {31'b0, stall_out}, 32'd1);
        send(RW_READ, 32'h1C, 32'h0, 4'd7);
        chk("t5_stall_free", {31'b0, stall_out}, 32'd0);
        idle(20);
        chk("t3_count", log_id.size(), 32'd7);
        for (int i = 0; i < 7 && i < log_id.size(); i++)
            chk($sformatf("t3_order_%0d", i), {28'b0, log_id[i]}, 32'(i + 1));
        if (log_data.size() > 1) chk("t3_word2", log_data[1], 32'hDEAD_BEEF);

        // Reset with three requests outstanding; the first write already landed.
        for (int i = 0; i < 4; i++) send(RW_WRITE, 32'h8, 32'h1111_1111, 4'(9 + i));
        @(negedge clk);
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ready", {31'b0, ready_out}, 32'd0);
        chk("t6_rst_id", {28'b0, id_out}, 32'd0);
        chk("t6_rst_data", data_out, 32'd0);
        chk("t6_rst_stall", {31'b0, stall_out}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_log();
        idle(8);
        chk("t6_no_completion", log_id.size(), 32'd0);
        send(RW_READ, 32'h8, 32'h0, 4'd13);
        idle(4);
        chk("t6_count", log_id.size(), 32'd1);
        if (log_id.size() > 0) chk("t6_cleared", log_data[0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
